// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns an M-stage load or store into one
// request/response bus transaction, aligns load data and stalls until done.
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memenM,
  input  logic [5:0]    opM,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  input  logic          pipe_stall,
  output logic [31:0]   readdataM,
  output logic          stall_memM,
  output logic          adelM,
  output logic          adesM,
  output logic [31:0]   badvaddrM,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [31:0]   data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [31:0]   data_rdata,
  output logic [1:0]    dbg_state
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] rdata_q;

  logic        is_load;
  logic        is_store;
  logic        addr_err;
  logic        valid;
  logic [1:0]  size;
  logic [31:0] raw_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (opM)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; size = 2'd2; end
      OP_SB:         begin is_store = 1'b1; size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size = 2'd2; end
      default:       begin is_load  = 1'b0; is_store = 1'b0; size = 2'd0; end
    endcase
  end

  always_comb begin
    addr_err = ((size == 2'd1) && aluoutM[0]) ||
               ((size == 2'd2) && (aluoutM[1:0] != 2'b00));
    adelM     = memenM && is_load  && addr_err;
    adesM     = memenM && is_store && addr_err;
    badvaddrM = (adelM || adesM) ? aluoutM : 32'h0;
    valid     = memenM && (is_load || is_store) && !addr_err;
  end

  // Bus request fields come straight from the M inputs, which the pipeline
  // holds stable for as long as stall_memM keeps it frozen.
  always_comb begin
    data_req   = rst && (((state_q == S_IDLE) && valid) || (state_q == S_ADDR));
    data_wr    = is_store;
    data_size  = size;
    data_addr  = aluoutM[AW-1:0];
    data_wstrb = 4'b0000;
    data_wdata = writedataM;
    if (is_store) begin
      case (size)
        2'd0: begin
          data_wstrb = 4'b0001 << aluoutM[1:0];
          data_wdata = {4{writedataM[7:0]}};
        end
        2'd1: begin
          data_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{writedataM[15:0]}};
        end
        default: begin
          data_wstrb = 4'b1111;
          data_wdata = writedataM;
        end
      endcase
    end
  end

  always_comb begin
    stall_memM = valid && !((state_q == S_DATA) && data_data_ok) &&
                 (state_q != S_DONE);
  end

  always_comb begin
    raw_word = 32'h0;
    if (((state_q == S_DATA) || (state_q == S_IDLE)) && data_data_ok)
      raw_word = data_rdata;
    else if (state_q == S_DONE)
      raw_word = rdata_q;
    sel_byte = 8'(raw_word >> {aluoutM[1:0], 3'b000});
    sel_half = aluoutM[1] ? raw_word[31:16] : raw_word[15:0];
    case (opM)
      OP_LB:   readdataM = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  readdataM = {24'h0, sel_byte};
      OP_LH:   readdataM = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  readdataM = {16'h0, sel_half};
      default: readdataM = raw_word;
    endcase
  end

  // A data_ok seen in IDLE or ADDR belongs to no request of ours and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid) state_q <= data_addr_ok ? S_DATA : S_ADDR;
        end
        S_ADDR: begin
          if (data_addr_ok) state_q <= S_DATA;
        end
        S_DATA: begin
          if (data_data_ok) begin
            rdata_q <= data_rdata;
            state_q <= pipe_stall ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (!pipe_stall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, alignment faults,
// slow-bus handshakes with downstream stall, and reset mid-transaction.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic [5:0]  opM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        pipe_stall;
  logic [31:0] readdataM;
  logic        stall_memM;
  logic        adelM;
  logic        adesM;
  logic [31:0] badvaddrM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_bad    = 0;

  mem_access_unit #(.AW(32)) dut (
    .clk(clk), .rst(rst), .memenM(memenM), .opM(opM), .aluoutM(aluoutM),
    .writedataM(writedataM), .pipe_stall(pipe_stall), .readdataM(readdataM),
    .stall_memM(stall_memM), .adelM(adelM), .adesM(adesM),
    .badvaddrM(badvaddrM), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    memenM = 1'b0; opM = 6'h0; aluoutM = 32'h0; writedataM = 32'h0;
    pipe_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = 32'h0;
  endtask

  // Single fast access: addr_ok in the first cycle, data_ok in the next.
  task automatic run_access(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            output logic req0, output logic wr0,
                            output logic [1:0] size0, output logic [3:0] strb0,
                            output logic [31:0] wdata0, output logic stall0,
                            output logic stall1, output logic [31:0] rd1);
    memenM = 1'b1; opM = op; aluoutM = addr; writedataM = wd;
    data_addr_ok = 1'b1; data_data_ok = 1'b0; pipe_stall = 1'b0;
    @(negedge clk);
    req0 = data_req; wr0 = data_wr; size0 = data_size; strb0 = data_wstrb;
    wdata0 = data_wdata; stall0 = stall_memM;
    next_cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
    @(negedge clk);
    stall1 = stall_memM; rd1 = readdataM;
    next_cycle();
    go_idle();
  endtask

  logic        r_req, r_wr, r_st0, r_st1;
  logic [1:0]  r_size;
  logic [3:0]  r_strb;
  logic [31:0] r_wdata, r_rd;
  int          req_cnt;

  initial begin
    go_idle();
    rst = 1'b0;
    #12;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(stall_memM), 32'd0);
    check("rst_rdata", readdataM, 32'h0);
    rst = 1'b1;
    next_cycle();

    // LW fast path
    run_access(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("lw_req", 32'(r_req), 32'd1);
    check("lw_wr", 32'(r_wr), 32'd0);
    check("lw_size", 32'(r_size), 32'd2);
    check("lw_strb", 32'(r_strb), 32'h0);
    check("lw_stall0", 32'(r_st0), 32'd1);
    check("lw_stall1", 32'(r_st1), 32'd0);
    check("lw_data", r_rd, 32'hDEADBEEF);
    check("lw_back_idle", 32'(dbg_state), 32'd0);

    // Byte / half extension
    run_access(6'h20, 32'h103, 32'h0, 32'h80FFFF00, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("lb_size", 32'(r_size), 32'd0);
    check("lb_data", r_rd, 32'hFFFFFF80);
    run_access(6'h24, 32'h103, 32'h0, 32'h80FFFF00, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("lbu_data", r_rd, 32'h00000080);
    run_access(6'h21, 32'h102, 32'h0, 32'h80FFFF00, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("lh_size", 32'(r_size), 32'd1);
    check("lh_data", r_rd, 32'hFFFF80FF);
    run_access(6'h25, 32'h100, 32'h0, 32'h80FFFF00, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("lhu_data", r_rd, 32'h0000FF00);

    // Stores
    run_access(6'h28, 32'h101, 32'h123456AB, 32'h0, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("sb_req", 32'(r_req), 32'd1);
    check("sb_wr", 32'(r_wr), 32'd1);
    check("sb_strb", 32'(r_strb), 32'b0010);
    check("sb_wdata", r_wdata, 32'hABABABAB);
    run_access(6'h29, 32'h102, 32'h123456AB, 32'h0, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("sh_strb", 32'(r_strb), 32'b1100);
    check("sh_wdata", r_wdata, 32'h56AB56AB);
    run_access(6'h2B, 32'h104, 32'h123456AB, 32'h0, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("sw_strb", 32'(r_strb), 32'b1111);
    check("sw_wdata", r_wdata, 32'h123456AB);
    check("sw_stall1", 32'(r_st1), 32'd0);

    // Alignment faults and unknown opcode
    memenM = 1'b1; opM = 6'h23; aluoutM = 32'h102; data_addr_ok = 1'b1;
    @(negedge clk);
    check("adel_flag", 32'(adelM), 32'd1);
    check("adel_ades", 32'(adesM), 32'd0);
    check("adel_bad", badvaddrM, 32'h102);
    check("adel_req", 32'(data_req), 32'd0);
    check("adel_stall", 32'(stall_memM), 32'd0);
    next_cycle();
    check("adel_state", 32'(dbg_state), 32'd0);
    opM = 6'h29; aluoutM = 32'h101;
    @(negedge clk);
    check("ades_flag", 32'(adesM), 32'd1);
    check("ades_adel", 32'(adelM), 32'd0);
    check("ades_bad", badvaddrM, 32'h101);
    check("ades_req", 32'(data_req), 32'd0);
    next_cycle();
    opM = 6'h22; aluoutM = 32'h100;
    @(negedge clk);
    check("badop_req", 32'(data_req), 32'd0);
    check("badop_stall", 32'(stall_memM), 32'd0);
    check("badop_bad", badvaddrM, 32'h0);
    next_cycle();
    go_idle();
    next_cycle();

    // Slow bus: addr_ok held off 3 cycles, then 2 cycles of pipe_stall in DONE
    memenM = 1'b1; opM = 6'h23; aluoutM = 32'h200; data_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_addr_ok = 1'b1;
      @(negedge clk);
      check($sformatf("slow_req%0d", i), 32'(data_req), 32'd1);
      check($sformatf("slow_addr%0d", i), data_addr, 32'h200);
      check($sformatf("slow_stall%0d", i), 32'(stall_memM), 32'd1);
      check($sformatf("slow_state%0d", i), 32'(dbg_state), (i == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    pipe_stall = 1'b1;
    req_cnt = 0;
    @(negedge clk);
    check("slow_in_data", 32'(dbg_state), 32'd2);
    check("slow_data_stall", 32'(stall_memM), 32'd0);
    check("slow_data_rd", readdataM, 32'hCAFEF00D);
    if (data_req) req_cnt++;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      pipe_stall = (i == 0);
      @(negedge clk);
      check($sformatf("done_state%0d", i), 32'(dbg_state), 32'd3);
      check($sformatf("done_rd%0d", i), readdataM, 32'hCAFEF00D);
      check($sformatf("done_stall%0d", i), 32'(stall_memM), 32'd0);
      if (data_req) req_cnt++;
    end
    check("slow_no_rereq", 32'(req_cnt), 32'd0);
    next_cycle();
    go_idle();
    @(negedge clk);
    check("slow_back_idle", 32'(dbg_state), 32'd0);
    next_cycle();

    // Reset while waiting for data
    memenM = 1'b1; opM = 6'h23; aluoutM = 32'h300; data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("rstm_in_data", 32'(dbg_state), 32'd2);
    next_cycle();
    #1 rst = 1'b0;
    #1;
    check("rstm_state", 32'(dbg_state), 32'd0);
    check("rstm_req", 32'(data_req), 32'd0);
    go_idle();
    next_cycle();
    rst = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    next_cycle();
    check("rstm_stray_ok", 32'(dbg_state), 32'd0);
    go_idle();
    run_access(6'h23, 32'h300, 32'h0, 32'h0BADF00D, r_req, r_wr, r_size,
               r_strb, r_wdata, r_st0, r_st1, r_rd);
    check("post_rst_req", 32'(r_req), 32'd1);
    check("post_rst_stall1", 32'(r_st1), 32'd0);
    check("post_rst_data", r_rd, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit, directly downstream of the datapath's M-stage registers (opM, aluoutM, writedataM, memenM).
- Converts each access into a single-beat request/response data-bus transaction with byte-lane strobes and size encoding.
- Aligns and sign- or zero-extends load data into readdataM.
- Raises a pipeline stall until the transaction completes.
- Flags misaligned addresses instead of issuing them.

Parameters:
- AW, 32, data-bus address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memenM  in  1  M-stage instruction is a load or store.
- opM  in  6  M-stage opcode.
- aluoutM  in  32  effective address.
- writedataM  in  32  store data, right-justified.
- pipe_stall  in  1  stall from other sources; the M stage will not advance this cycle.
- readdataM  out  32  extended load data to the W register.
- stall_memM  out  1  hold the pipeline.
- adelM  out  1  load address error.
- adesM  out  1  store address error.
- badvaddrM  out  32  faulting address.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  AW  byte address (aluoutM).
- data_wstrb  out  4  byte-lane strobes.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  response valid this cycle.
- data_rdata  in  32  read word.

Behaviour:
- Opcodes:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - Any other opM with memenM=1 is treated as no access.
- Access condition: valid = memenM & recognised op & no alignment error.
- Alignment errors (combinational):
  - Halfword error when addr[0]=1.
  - Word error when addr[1:0]!=0.
  - Load error drives adelM=1; store error drives adesM=1.
  - badvaddrM = aluoutM on any error, otherwise 0.
  - On error: no bus request, stall_memM=0.
- Strobes and write data:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111, wdata = wd.
  - Loads: wstrb = 0000.
- Load data: select the byte or half at addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- readdataM source:
  - In DATA, and in IDLE, the source is data_rdata while data_data_ok=1.
  - In DONE, the source is the captured word.
  - Otherwise readdataM = 0.
- FSM, states IDLE, ADDR, DATA, DONE; reset state IDLE.
  - IDLE: data_req = valid (combinational). If valid & addr_ok, go to DATA. If valid & !addr_ok, go to ADDR.
  - ADDR: data_req=1, with address, size, strobes and data held from the M inputs, which are stable while stalled. On addr_ok, go to DATA.
  - DATA: data_req=0. On data_ok, capture data_rdata. Then go to DONE if pipe_stall=1, else IDLE.
  - DONE: data_req=0. Hold the captured data. Go to IDLE when pipe_stall=0.
- Stall equation: stall_memM = valid & !(state==DATA & data_ok) & state!=DONE.
  - Minimum stall is 1 cycle: addr_ok in the first cycle, data_ok in the next.
- A data_ok that arrives in the same cycle as addr_ok is ignored; the bus returns data_ok no earlier than the cycle after addr_ok.
- A new access cannot be issued while in DATA or DONE. The instruction that completes in DONE is the same M instruction, so it is never re-issued.
- pipe_stall=1 while in IDLE with a valid access does not block issue.
- Reset: rst low at any time, mid-transaction included, forces:
  - state = IDLE;
  - data_req = 0;
  - captured data = 0;
  - all outputs derived from inputs only.
  - An outstanding bus response after reset is ignored.

Test Plan:
- LW at 0x100, addr_ok in cycle 0, data_ok in cycle 1 with rdata 0xDEADBEEF -> req=1, size=2 in cycle 0; stall=1 in cycle 0 and 0 in cycle 1; readdataM=0xDEADBEEF in cycle 1.
- LB at 0x103 with rdata 0x80FF_FF00, then LBU at the same address -> readdataM 0xFFFFFF80, then 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB at 0x101, wd=0x123456AB -> wstrb=0010, wdata=0xABABABAB, wr=1. SH at 0x102 -> wstrb=1100, wdata=0x56AB56AB.
- LW at 0x102 -> adelM=1, badvaddrM=0x102, req=0, stall=0. SH at 0x101 -> adesM=1.
- addr_ok withheld 3 cycles, then data_ok while pipe_stall=1 held for 2 cycles -> req high for 4 cycles with stable address; FSM passes through DATA, then sits 2 cycles in DONE with readdataM held; no second request.
- rst pulsed low while in DATA -> data_req=0 and state IDLE immediately; a subsequent LW completes normally.
